// File: rtl/ex_mem_hazard_unit_pkg.sv
// Shared definitions for the EX/MEM pipeline register and hazard unit:
// widths, forwarding select encodings, MemtoReg encodings and the EX/MEM payload.
package ex_mem_hazard_unit_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned MTR_W  = 2;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   // EX-stage ALU operand selects
   localparam logic [SEL_W-1:0] FWD_REG = 2'd0;
   localparam logic [SEL_W-1:0] FWD_WB  = 2'd1;
   localparam logic [SEL_W-1:0] FWD_MEM = 2'd2;

   // ID-stage branch comparator selects
   localparam logic [SEL_W-1:0] FWDID_REG = 2'd0;
   localparam logic [SEL_W-1:0] FWDID_MEM = 2'd1;
   localparam logic [SEL_W-1:0] FWDID_EX  = 2'd2;

   // Writeback source select
   localparam logic [MTR_W-1:0] MTR_ALU = 2'd0;
   localparam logic [MTR_W-1:0] MTR_MEM = 2'd1;
   localparam logic [MTR_W-1:0] MTR_PC4 = 2'd2;

   // Contents of the EX/MEM pipeline register
   typedef struct packed {
      logic [MTR_W-1:0]  mem_to_reg;
      logic              reg_write;
      logic              mem_write;
      logic              mem_read;
      logic [REG_AW-1:0] waddr;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] wdata;
   } ex_mem_t;

endpackage

// File: rtl/ex_mem_hazard_unit_fwd_match.sv
// Producer/consumer register match: an enabled write to a nonzero register
// whose address equals the source register being read.
module ex_mem_hazard_unit_fwd_match
   import ex_mem_hazard_unit_pkg::*;
(
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [REG_AW-1:0] i_raddr,
   output logic              o_hit_c
);

   assign o_hit_c = i_we && (i_waddr != REG_ZERO) && (i_waddr == i_raddr);

endmodule

// File: rtl/ex_mem_hazard_unit.sv
// EX/MEM pipeline register plus forwarding-select and hazard/flush generation
// for the 5-stage MIPS core.
// Build option FWD_EX_TO_ID_EN: when defined, the ID branch comparator may take
// the EX-stage ALU result directly; when undefined, a branch that depends on
// an EX-stage write is stalled for one cycle instead.
module ex_mem_hazard_unit
   import ex_mem_hazard_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [MTR_W-1:0]  WB_MemtoReg_ex,
   output logic [MTR_W-1:0]  WB_MemtoReg_mem,
   input  logic              WB_RegWrite_ex,
   output logic              WB_RegWrite_mem,
   input  logic              MEM_MemWrite_ex,
   output logic              MEM_MemWrite_mem,
   input  logic              MEM_MemRead_ex,
   output logic              MEM_MemRead_mem,
   input  logic [REG_AW-1:0] RegWriteAddress_ex,
   output logic [REG_AW-1:0] RegWriteAddress_mem,
   input  logic [DATA_W-1:0] PC_ex,
   output logic [DATA_W-1:0] PC_mem,
   input  logic [DATA_W-1:0] ALU_out,
   output logic [DATA_W-1:0] ALUResult_mem,
   input  logic [DATA_W-1:0] RealOut2,
   output logic [DATA_W-1:0] MemWriteData_mem,
   input  logic              WB_RegWrite_wb,
   input  logic [REG_AW-1:0] RegWriteAddress_wb,
   input  logic [REG_AW-1:0] RsAddress_ex,
   input  logic [REG_AW-1:0] RtAddress_ex,
   input  logic [REG_AW-1:0] RsAddress_id,
   input  logic [REG_AW-1:0] RtAddress_id,
   input  logic              Branch_id,
   input  logic              Whether_branch,
   input  logic              Whether_jump,
   output logic [SEL_W-1:0]  ForwardA,
   output logic [SEL_W-1:0]  ForwardB,
   output logic [SEL_W-1:0]  ForwardC,
   output logic [SEL_W-1:0]  ForwardD,
   output logic              Keep_current_PC,
   output logic              IF_ID_keep,
   output logic              stall,
   output logic              flush
);

   ex_mem_t r_ex_mem;
   ex_mem_t w_ex_mem_d;

   logic w_mem_rs_ex, w_mem_rt_ex, w_wb_rs_ex, w_wb_rt_ex;
   logic w_ex_rs_id, w_ex_rt_id, w_mem_rs_id, w_mem_rt_id;
   logic w_lu_rs_id, w_lu_rt_id, w_ld_rs_id, w_ld_rt_id;
   logic w_ex_fwd_en;
   logic w_ex_dep_stall;
   logic w_hazard;

   assign w_ex_mem_d = '{mem_to_reg: WB_MemtoReg_ex,
                         reg_write:  WB_RegWrite_ex,
                         mem_write:  MEM_MemWrite_ex,
                         mem_read:   MEM_MemRead_ex,
                         waddr:      RegWriteAddress_ex,
                         pc:         PC_ex,
                         alu_result: ALU_out,
                         wdata:      RealOut2};

   // EX/MEM pipeline register: unconditional capture, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) r_ex_mem <= '0;
      else       r_ex_mem <= w_ex_mem_d;
   end

   assign WB_MemtoReg_mem     = r_ex_mem.mem_to_reg;
   assign WB_RegWrite_mem     = r_ex_mem.reg_write;
   assign MEM_MemWrite_mem    = r_ex_mem.mem_write;
   assign MEM_MemRead_mem     = r_ex_mem.mem_read;
   assign RegWriteAddress_mem = r_ex_mem.waddr;
   assign PC_mem              = r_ex_mem.pc;
   assign ALUResult_mem       = r_ex_mem.alu_result;
   assign MemWriteData_mem    = r_ex_mem.wdata;

   // Register matches for EX-stage operands (MEM and WB producers)
   ex_mem_hazard_unit_fwd_match u_mem_rs_ex (.i_we(r_ex_mem.reg_write), .i_waddr(r_ex_mem.waddr),    .i_raddr(RsAddress_ex), .o_hit_c(w_mem_rs_ex));
   ex_mem_hazard_unit_fwd_match u_mem_rt_ex (.i_we(r_ex_mem.reg_write), .i_waddr(r_ex_mem.waddr),    .i_raddr(RtAddress_ex), .o_hit_c(w_mem_rt_ex));
   ex_mem_hazard_unit_fwd_match u_wb_rs_ex  (.i_we(WB_RegWrite_wb),     .i_waddr(RegWriteAddress_wb), .i_raddr(RsAddress_ex), .o_hit_c(w_wb_rs_ex));
   ex_mem_hazard_unit_fwd_match u_wb_rt_ex  (.i_we(WB_RegWrite_wb),     .i_waddr(RegWriteAddress_wb), .i_raddr(RtAddress_ex), .o_hit_c(w_wb_rt_ex));

   // Register matches for ID-stage operands (EX and MEM producers)
   ex_mem_hazard_unit_fwd_match u_ex_rs_id  (.i_we(WB_RegWrite_ex),     .i_waddr(RegWriteAddress_ex), .i_raddr(RsAddress_id), .o_hit_c(w_ex_rs_id));
   ex_mem_hazard_unit_fwd_match u_ex_rt_id  (.i_we(WB_RegWrite_ex),     .i_waddr(RegWriteAddress_ex), .i_raddr(RtAddress_id), .o_hit_c(w_ex_rt_id));
   ex_mem_hazard_unit_fwd_match u_mem_rs_id (.i_we(r_ex_mem.reg_write), .i_waddr(r_ex_mem.waddr),    .i_raddr(RsAddress_id), .o_hit_c(w_mem_rs_id));
   ex_mem_hazard_unit_fwd_match u_mem_rt_id (.i_we(r_ex_mem.reg_write), .i_waddr(r_ex_mem.waddr),    .i_raddr(RtAddress_id), .o_hit_c(w_mem_rt_id));

   // Load in EX whose rt destination is read by ID (load-use)
   ex_mem_hazard_unit_fwd_match u_lu_rs_id  (.i_we(MEM_MemRead_ex),     .i_waddr(RtAddress_ex),       .i_raddr(RsAddress_id), .o_hit_c(w_lu_rs_id));
   ex_mem_hazard_unit_fwd_match u_lu_rt_id  (.i_we(MEM_MemRead_ex),     .i_waddr(RtAddress_ex),       .i_raddr(RtAddress_id), .o_hit_c(w_lu_rt_id));

   // Load in MEM whose destination feeds an ID branch compare
   ex_mem_hazard_unit_fwd_match u_ld_rs_id  (.i_we(r_ex_mem.mem_read),  .i_waddr(r_ex_mem.waddr),    .i_raddr(RsAddress_id), .o_hit_c(w_ld_rs_id));
   ex_mem_hazard_unit_fwd_match u_ld_rt_id  (.i_we(r_ex_mem.mem_read),  .i_waddr(r_ex_mem.waddr),    .i_raddr(RtAddress_id), .o_hit_c(w_ld_rt_id));

`ifdef FWD_EX_TO_ID_EN
   assign w_ex_fwd_en    = 1'b1;
   assign w_ex_dep_stall = 1'b0;
`else
   // Without the EX-to-ID path a dependent branch waits one cycle for MEM
   assign w_ex_fwd_en    = 1'b0;
   assign w_ex_dep_stall = Branch_id & (w_ex_rs_id | w_ex_rt_id);
`endif

   // EX operand selects: the younger MEM result wins over WB
   always_comb begin
      ForwardA = FWD_REG;
      ForwardB = FWD_REG;
      if (w_mem_rs_ex)     ForwardA = FWD_MEM;
      else if (w_wb_rs_ex) ForwardA = FWD_WB;
      if (w_mem_rt_ex)     ForwardB = FWD_MEM;
      else if (w_wb_rt_ex) ForwardB = FWD_WB;
   end

   // ID compare selects: EX result (if enabled) wins over MEM
   always_comb begin
      ForwardC = FWDID_REG;
      ForwardD = FWDID_REG;
      if (w_ex_fwd_en && w_ex_rs_id) ForwardC = FWDID_EX;
      else if (w_mem_rs_id)          ForwardC = FWDID_MEM;
      if (w_ex_fwd_en && w_ex_rt_id) ForwardD = FWDID_EX;
      else if (w_mem_rt_id)          ForwardD = FWDID_MEM;
   end

   // Hazard detection; stall takes priority over flush, all quiet in reset
   always_comb begin
      Keep_current_PC = 1'b0;
      IF_ID_keep      = 1'b0;
      stall           = 1'b0;
      flush           = 1'b0;
      w_hazard = w_lu_rs_id | w_lu_rt_id
               | (Branch_id & (w_ld_rs_id | w_ld_rt_id))
               | w_ex_dep_stall;
      if (!reset) begin
         Keep_current_PC = w_hazard;
         IF_ID_keep      = w_hazard;
         stall           = w_hazard;
         flush           = (Whether_branch | Whether_jump) & ~w_hazard;
      end
   end

endmodule

// File: tb/tb_ex_mem_hazard_unit.sv
// Self-checking bench for ex_mem_hazard_unit: directed table, multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_ex_mem_hazard_unit;

`ifdef FWD_EX_TO_ID_EN
   localparam bit EXFWD = 1'b1;
`else
   localparam bit EXFWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  WB_MemtoReg_ex;
   logic [1:0]  WB_MemtoReg_mem;
   logic        WB_RegWrite_ex, WB_RegWrite_mem;
   logic        MEM_MemWrite_ex, MEM_MemWrite_mem;
   logic        MEM_MemRead_ex, MEM_MemRead_mem;
   logic [4:0]  RegWriteAddress_ex, RegWriteAddress_mem;
   logic [31:0] PC_ex, PC_mem, ALU_out, ALUResult_mem, RealOut2, MemWriteData_mem;
   logic        WB_RegWrite_wb;
   logic [4:0]  RegWriteAddress_wb, RsAddress_ex, RtAddress_ex, RsAddress_id, RtAddress_id;
   logic        Branch_id, Whether_branch, Whether_jump;
   logic [1:0]  ForwardA, ForwardB, ForwardC, ForwardD;
   logic        Keep_current_PC, IF_ID_keep, stall, flush;

   int n_checks = 0;
   int n_errors = 0;

   // Model of the pipeline register contents
   logic [1:0]  m_mtr;
   logic        m_rw, m_mw, m_mr;
   logic [4:0]  m_wa;
   logic [31:0] m_pc, m_alu, m_wd;

   ex_mem_hazard_unit dut (
      .clk(clk), .reset(reset),
      .WB_MemtoReg_ex(WB_MemtoReg_ex), .WB_MemtoReg_mem(WB_MemtoReg_mem),
      .WB_RegWrite_ex(WB_RegWrite_ex), .WB_RegWrite_mem(WB_RegWrite_mem),
      .MEM_MemWrite_ex(MEM_MemWrite_ex), .MEM_MemWrite_mem(MEM_MemWrite_mem),
      .MEM_MemRead_ex(MEM_MemRead_ex), .MEM_MemRead_mem(MEM_MemRead_mem),
      .RegWriteAddress_ex(RegWriteAddress_ex), .RegWriteAddress_mem(RegWriteAddress_mem),
      .PC_ex(PC_ex), .PC_mem(PC_mem),
      .ALU_out(ALU_out), .ALUResult_mem(ALUResult_mem),
      .RealOut2(RealOut2), .MemWriteData_mem(MemWriteData_mem),
      .WB_RegWrite_wb(WB_RegWrite_wb), .RegWriteAddress_wb(RegWriteAddress_wb),
      .RsAddress_ex(RsAddress_ex), .RtAddress_ex(RtAddress_ex),
      .RsAddress_id(RsAddress_id), .RtAddress_id(RtAddress_id),
      .Branch_id(Branch_id), .Whether_branch(Whether_branch), .Whether_jump(Whether_jump),
      .ForwardA(ForwardA), .ForwardB(ForwardB), .ForwardC(ForwardC), .ForwardD(ForwardD),
      .Keep_current_PC(Keep_current_PC), .IF_ID_keep(IF_ID_keep),
      .stall(stall), .flush(flush)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) begin
         m_mtr <= '0; m_rw <= 1'b0; m_mw <= 1'b0; m_mr <= 1'b0;
         m_wa <= '0; m_pc <= '0; m_alu <= '0; m_wd <= '0;
      end else begin
         m_mtr <= WB_MemtoReg_ex; m_rw <= WB_RegWrite_ex; m_mw <= MEM_MemWrite_ex;
         m_mr <= MEM_MemRead_ex; m_wa <= RegWriteAddress_ex; m_pc <= PC_ex;
         m_alu <= ALU_out; m_wd <= RealOut2;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic writes(input logic we, input logic [4:0] wa, input logic [4:0] ra);
      return we && (wa != 5'd0) && (wa == ra);
   endfunction

   task automatic clear_inputs();
      WB_MemtoReg_ex = '0; WB_RegWrite_ex = 0; MEM_MemWrite_ex = 0; MEM_MemRead_ex = 0;
      RegWriteAddress_ex = '0; PC_ex = '0; ALU_out = '0; RealOut2 = '0;
      WB_RegWrite_wb = 0; RegWriteAddress_wb = '0; RsAddress_ex = '0; RtAddress_ex = '0;
      RsAddress_id = '0; RtAddress_id = '0; Branch_id = 0; Whether_branch = 0; Whether_jump = 0;
   endtask

   // Compare registered outputs against the model
   task automatic check_mem(input string tag);
      chk({tag, ".MemtoReg_mem"}, 32'(WB_MemtoReg_mem), 32'(m_mtr));
      chk({tag, ".RegWrite_mem"}, 32'(WB_RegWrite_mem), 32'(m_rw));
      chk({tag, ".MemWrite_mem"}, 32'(MEM_MemWrite_mem), 32'(m_mw));
      chk({tag, ".MemRead_mem"}, 32'(MEM_MemRead_mem), 32'(m_mr));
      chk({tag, ".WAddr_mem"}, 32'(RegWriteAddress_mem), 32'(m_wa));
      chk({tag, ".PC_mem"}, PC_mem, m_pc);
      chk({tag, ".ALUResult_mem"}, ALUResult_mem, m_alu);
      chk({tag, ".MemWriteData_mem"}, MemWriteData_mem, m_wd);
   endtask

   // Compare combinational outputs against rules computed from model state
   task automatic check_comb(input string tag);
      logic [1:0] ea, eb, ec, ed;
      logic hz, fl;
      ea = writes(m_rw, m_wa, RsAddress_ex) ? 2'd2 :
           writes(WB_RegWrite_wb, RegWriteAddress_wb, RsAddress_ex) ? 2'd1 : 2'd0;
      eb = writes(m_rw, m_wa, RtAddress_ex) ? 2'd2 :
           writes(WB_RegWrite_wb, RegWriteAddress_wb, RtAddress_ex) ? 2'd1 : 2'd0;
      ec = (EXFWD && writes(WB_RegWrite_ex, RegWriteAddress_ex, RsAddress_id)) ? 2'd2 :
           writes(m_rw, m_wa, RsAddress_id) ? 2'd1 : 2'd0;
      ed = (EXFWD && writes(WB_RegWrite_ex, RegWriteAddress_ex, RtAddress_id)) ? 2'd2 :
           writes(m_rw, m_wa, RtAddress_id) ? 2'd1 : 2'd0;
      hz = writes(MEM_MemRead_ex, RtAddress_ex, RsAddress_id) ||
           writes(MEM_MemRead_ex, RtAddress_ex, RtAddress_id) ||
           (Branch_id && (writes(m_mr, m_wa, RsAddress_id) || writes(m_mr, m_wa, RtAddress_id))) ||
           (!EXFWD && Branch_id && (writes(WB_RegWrite_ex, RegWriteAddress_ex, RsAddress_id) ||
                                    writes(WB_RegWrite_ex, RegWriteAddress_ex, RtAddress_id)));
      fl = (Whether_branch || Whether_jump) && !hz;
      if (reset) begin hz = 1'b0; fl = 1'b0; end
      chk({tag, ".ForwardA"}, 32'(ForwardA), 32'(ea));
      chk({tag, ".ForwardB"}, 32'(ForwardB), 32'(eb));
      chk({tag, ".ForwardC"}, 32'(ForwardC), 32'(ec));
      chk({tag, ".ForwardD"}, 32'(ForwardD), 32'(ed));
      chk({tag, ".Keep_current_PC"}, 32'(Keep_current_PC), 32'(hz));
      chk({tag, ".IF_ID_keep"}, 32'(IF_ID_keep), 32'(hz));
      chk({tag, ".stall"}, 32'(stall), 32'(hz));
      chk({tag, ".flush"}, 32'(flush), 32'(fl));
   endtask

   typedef struct {
      string      name;
      logic       p_we, p_rd; logic [4:0] p_wa;        // producer preloaded into MEM
      logic       ex_we, ex_rd; logic [4:0] ex_wa;     // instruction now in EX
      logic       wb_we; logic [4:0] wb_wa;
      logic [4:0] rs_ex, rt_ex, rs_id, rt_id;
      logic       br, wbr, wj;
      logic [1:0] fa, fb, fc, fd;
      logic       st, fl;
   } vec_t;

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{"fa_mem",        1,0,8,  0,0,0,  0,0,  8,0,0,0, 0,0,0, 2,0,0,0, 0,0};
      vecs[1]  = '{"mem_over_wb",   1,0,8,  0,0,0,  1,8,  8,8,0,0, 0,0,0, 2,2,0,0, 0,0};
      vecs[2]  = '{"fb_wb",         1,0,10, 0,0,0,  1,9,  0,9,0,0, 0,0,0, 0,1,0,0, 0,0};
      vecs[3]  = '{"dest_zero",     1,0,0,  0,0,0,  1,0,  0,0,0,0, 0,0,0, 0,0,0,0, 0,0};
      vecs[4]  = '{"mem_we_off",    0,0,8,  0,0,0,  0,0,  8,0,0,0, 0,0,0, 0,0,0,0, 0,0};
      vecs[5]  = '{"load_use_rs",   0,0,0,  0,1,0,  0,0,  0,5,5,0, 0,0,0, 0,0,0,0, 1,0};
      vecs[6]  = '{"load_use_br",   0,0,0,  0,1,0,  0,0,  0,5,5,0, 1,1,0, 0,0,0,0, 1,0};
      vecs[7]  = '{"load_use_rt",   0,0,0,  0,1,0,  0,0,  0,6,0,6, 0,0,0, 0,0,0,0, 1,0};
      vecs[8]  = '{"load_use_r0",   0,0,0,  0,1,0,  0,0,  0,0,0,0, 0,1,0, 0,0,0,0, 0,1};
      vecs[9]  = '{"fc_ex_mem",     1,0,3,  1,0,3,  0,0,  0,0,3,0, 0,0,0, 0,0,EXFWD?2'd2:2'd1,0, 0,0};
      vecs[10] = '{"fc_ex_branch",  1,0,3,  1,0,3,  0,0,  0,0,3,0, 1,0,0, 0,0,EXFWD?2'd2:2'd1,0, !EXFWD,0};
      vecs[11] = '{"branch_load",   1,1,7,  0,0,0,  0,0,  0,0,0,7, 1,0,0, 0,0,0,1, 1,0};
      vecs[12] = '{"load_no_branch",1,1,7,  0,0,0,  0,0,  0,0,0,7, 0,1,0, 0,0,0,1, 0,1};
      vecs[13] = '{"jump",          0,0,0,  0,0,0,  0,0,  0,0,0,0, 0,0,1, 0,0,0,0, 0,1};
      vecs[14] = '{"fd_ex",         0,0,0,  1,0,4,  0,0,  0,0,0,4, 0,0,0, 0,0,0,EXFWD?2'd2:2'd0, 0,0};

      clear_inputs();

      // Reset with nonzero EX inputs and active hazard/flush conditions
      reset = 1'b1;
      WB_MemtoReg_ex = 2'd2; WB_RegWrite_ex = 1; MEM_MemWrite_ex = 1; MEM_MemRead_ex = 1;
      RegWriteAddress_ex = 5'd5; PC_ex = 32'h400; ALU_out = 32'hdead; RealOut2 = 32'hbeef;
      RtAddress_ex = 5'd5; RsAddress_id = 5'd5; Whether_jump = 1;
      @(posedge clk); @(negedge clk);
      check_mem("reset");
      chk("reset.stall", 32'(stall), 32'd0);
      chk("reset.Keep_current_PC", 32'(Keep_current_PC), 32'd0);
      chk("reset.IF_ID_keep", 32'(IF_ID_keep), 32'd0);
      chk("reset.flush", 32'(flush), 32'd0);
      chk("reset.WAddr_mem0", 32'(RegWriteAddress_mem), 32'd0);
      clear_inputs();
      reset = 1'b0;
      RsAddress_ex = 5'd0;
      #1 chk("post_reset.ForwardA", 32'(ForwardA), 32'd0);

      // ALU result capture and MEM forwarding
      @(negedge clk);
      ALU_out = 32'h1234; RegWriteAddress_ex = 5'd8; WB_RegWrite_ex = 1;
      @(posedge clk); @(negedge clk);
      clear_inputs();
      chk("cap.ALUResult_mem", ALUResult_mem, 32'h1234);
      chk("cap.WAddr_mem", 32'(RegWriteAddress_mem), 32'd8);
      RsAddress_ex = 5'd8;
      #1 chk("cap.ForwardA_mem", 32'(ForwardA), 32'd2);
      WB_RegWrite_wb = 1; RegWriteAddress_wb = 5'd8;
      #1 chk("cap.ForwardA_mem_wins", 32'(ForwardA), 32'd2);

      // Directed table
      foreach (vecs[i]) begin
         @(negedge clk);
         clear_inputs();
         WB_RegWrite_ex = vecs[i].p_we; MEM_MemRead_ex = vecs[i].p_rd;
         RegWriteAddress_ex = vecs[i].p_wa;
         @(posedge clk); @(negedge clk);
         WB_RegWrite_ex = vecs[i].ex_we; MEM_MemRead_ex = vecs[i].ex_rd;
         RegWriteAddress_ex = vecs[i].ex_wa;
         WB_RegWrite_wb = vecs[i].wb_we; RegWriteAddress_wb = vecs[i].wb_wa;
         RsAddress_ex = vecs[i].rs_ex; RtAddress_ex = vecs[i].rt_ex;
         RsAddress_id = vecs[i].rs_id; RtAddress_id = vecs[i].rt_id;
         Branch_id = vecs[i].br; Whether_branch = vecs[i].wbr; Whether_jump = vecs[i].wj;
         #1;
         chk({vecs[i].name, ".ForwardA"}, 32'(ForwardA), 32'(vecs[i].fa));
         chk({vecs[i].name, ".ForwardB"}, 32'(ForwardB), 32'(vecs[i].fb));
         chk({vecs[i].name, ".ForwardC"}, 32'(ForwardC), 32'(vecs[i].fc));
         chk({vecs[i].name, ".ForwardD"}, 32'(ForwardD), 32'(vecs[i].fd));
         chk({vecs[i].name, ".stall"}, 32'(stall), 32'(vecs[i].st));
         chk({vecs[i].name, ".keep"}, 32'(Keep_current_PC & IF_ID_keep), 32'(vecs[i].st));
         chk({vecs[i].name, ".flush"}, 32'(flush), 32'(vecs[i].fl));
      end

      // lw $5 in EX, taken beq on $5 in ID: load-use, then branch-load, then flush
      @(negedge clk);
      clear_inputs();
      MEM_MemRead_ex = 1; WB_RegWrite_ex = 1; RegWriteAddress_ex = 5'd5; RtAddress_ex = 5'd5;
      RsAddress_id = 5'd5; Branch_id = 1; Whether_branch = 1;
      #1 chk("seq.c1.stall", 32'(stall), 32'd1);
      chk("seq.c1.flush", 32'(flush), 32'd0);
      @(posedge clk); @(negedge clk);
      MEM_MemRead_ex = 0; WB_RegWrite_ex = 0; RegWriteAddress_ex = 5'd0; RtAddress_ex = 5'd0;
      #1 chk("seq.c2.stall", 32'(stall), 32'd1);
      chk("seq.c2.flush", 32'(flush), 32'd0);
      chk("seq.c2.ForwardC", 32'(ForwardC), 32'd1);
      @(posedge clk); @(negedge clk);
      #1 chk("seq.c3.stall", 32'(stall), 32'd0);
      chk("seq.c3.flush", 32'(flush), 32'd1);

      // Randomized traffic with a narrow register range to provoke matches
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         check_mem("rnd");
         reset = ($urandom_range(0, 49) == 0);
         WB_MemtoReg_ex = 2'($urandom_range(0, 2));
         WB_RegWrite_ex = 1'($urandom);
         MEM_MemWrite_ex = 1'($urandom);
         MEM_MemRead_ex = 1'($urandom);
         RegWriteAddress_ex = 5'($urandom_range(0, 3));
         PC_ex = $urandom; ALU_out = $urandom; RealOut2 = $urandom;
         WB_RegWrite_wb = 1'($urandom);
         RegWriteAddress_wb = 5'($urandom_range(0, 3));
         RsAddress_ex = 5'($urandom_range(0, 3));
         RtAddress_ex = 5'($urandom_range(0, 3));
         RsAddress_id = 5'($urandom_range(0, 3));
         RtAddress_id = 5'($urandom_range(0, 3));
         Branch_id = 1'($urandom);
         Whether_branch = Branch_id & 1'($urandom);
         Whether_jump = ($urandom_range(0, 7) == 0);
         #1 check_comb("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_hazard_unit.md
# ex_mem_hazard_unit

Pipeline control block for the 5-stage MIPS core. It holds the EX/MEM pipeline register and generates the forwarding selects for the EX-stage ALU operand muxes and the ID-stage branch comparator. It also generates the hazard controls: PC hold, IF/ID hold, ID/EX bubble and IF/ID flush. It sits between the ID_EX register and the data memory and talks combinationally to the ID stage.

## Interface
Parameters: none. Select encodings come from the shared package.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- WB_MemtoReg_ex in 2 / WB_MemtoReg_mem out 2  writeback source select, registered
- WB_RegWrite_ex in 1 / WB_RegWrite_mem out 1  register-write enable, registered
- MEM_MemWrite_ex in 1 / MEM_MemWrite_mem out 1  store enable, registered
- MEM_MemRead_ex in 1 / MEM_MemRead_mem out 1  load enable, registered
- RegWriteAddress_ex in 5 / RegWriteAddress_mem out 5  destination register, registered
- PC_ex in 32 / PC_mem out 32  instruction PC, registered
- ALU_out in 32 / ALUResult_mem out 32  ALU result, registered
- RealOut2 in 32 / MemWriteData_mem out 32  forwarded rt value (store data), registered
- WB_RegWrite_wb  in  1  WB-stage write enable
- RegWriteAddress_wb  in  5  WB-stage destination
- RsAddress_ex, RtAddress_ex  in  5 each  EX-stage source registers
- RsAddress_id, RtAddress_id  in  5 each  ID-stage source registers
- Branch_id  in  1  ID instruction is beq/bne
- Whether_branch  in  1  branch taken, resolved in ID
- Whether_jump  in  1  j/jal/jr decoded in ID
- ForwardA, ForwardB  out  2 each  EX operand selects: 0 = ID_EX value, 1 = WB write data, 2 = ALUResult_mem
- ForwardC, ForwardD  out  2 each  ID compare selects: 0 = register file, 1 = ALUResult_mem, 2 = ALU_out
- Keep_current_PC, IF_ID_keep  out  1 each  hold PC / hold IF_ID (always equal)
- stall  out  1  insert bubble into ID_EX
- flush  out  1  clear IF_ID

## Operation
- EX/MEM register: every edge, all *_mem outputs are loaded from the matching *_ex inputs. There is no enable and no flush.
- ForwardA (for rs_ex), evaluated in priority order:
  - 2 if WB_RegWrite_mem and RegWriteAddress_mem≠0 and RegWriteAddress_mem==RsAddress_ex;
  - otherwise 1 if the same condition holds with the WB-stage signals;
  - otherwise 0.
- ForwardB: same rule, applied to RtAddress_ex. The MEM stage always wins over WB.
- ForwardC (for rs_id), evaluated in priority order:
  - 2 if WB_RegWrite_ex and RegWriteAddress_ex≠0 and RegWriteAddress_ex==RsAddress_id;
  - otherwise 1 if the same condition holds with the MEM-stage signals;
  - otherwise 0.
- ForwardD: same rule, applied to RtAddress_id. WB-to-ID is not handled here; the register-file bypass covers it.
- Load-use hazard: asserted when MEM_MemRead_ex and RtAddress_ex≠0 and RtAddress_ex equals RsAddress_id or RtAddress_id.
- Branch-load hazard: asserted when Branch_id and MEM_MemRead_mem and RegWriteAddress_mem≠0 and RegWriteAddress_mem matches an ID source.
- hazard = load-use OR branch-load. When hazard is asserted, Keep_current_PC = IF_ID_keep = stall = 1.
- flush = (Whether_branch | Whether_jump) & ~hazard. Stall has priority; the flush re-evaluates after the stall.
- While reset is high, all four hazard outputs are forced to 0.

## Timing
- Register latency is 1 cycle. One edge with reset high clears every *_mem output to 0.
- Because WB_RegWrite_mem resets to 0, ForwardA/B cannot select 2 immediately after reset.
- Forward* and hazard outputs are purely combinational, with no added cycles. A load-use stall lasts exactly 1 cycle; a branch-load stall adds a second cycle.
- When stall, flush and a new EX result occur in the same cycle, the register still captures the EX values. Bubbling is done upstream in ID_EX.

## Configuration
- FWD_EX_TO_ID_EN defined: ForwardC/D may select 2 (ALU_out) as described in Operation.
- FWD_EX_TO_ID_EN undefined:
  - ForwardC/D never select 2;
  - the hazard term also includes Branch_id & WB_RegWrite_ex & RegWriteAddress_ex≠0 & RegWriteAddress_ex matching an ID source (1-cycle stall).

## Structure
- Shared package holds:
  - forwarding select constants FWD_REG/FWD_WB/FWD_MEM and FWDID_REG/FWDID_MEM/FWDID_EX;
  - MemtoReg encodings (ALU = 0, MEM = 1, PC+4 = 2);
  - REG_ZERO = 5'd0.
- One natural sub-module, fwd_match: the write-enable, nonzero-address and address-equality comparator, instantiated per stage/source pair.

## Test plan
- Reset for 1 edge with all *_ex inputs nonzero -> all *_mem = 0 and hazard outputs 0 while reset is high.
- ALU_out=0x1234 with RegWriteAddress_ex=8 and RegWrite, then one edge -> ALUResult_mem=0x1234, RegWriteAddress_mem=8. Then RsAddress_ex=8 -> ForwardA=2. With WB also writing 8 -> ForwardA stays 2.
- WB writes 9, MEM writes 10, RtAddress_ex=9 -> ForwardB=1. Same setup with destination 0 and RtAddress_ex=0 -> ForwardB=0.
- MEM_MemRead_ex=1 with RtAddress_ex=5 and RsAddress_id=5 -> Keep_current_PC=IF_ID_keep=stall=1. With Whether_branch=1 also set, flush stays 0 until the hazard clears.
- EX writes 3 and MEM writes 3, with RsAddress_id=3 -> ForwardC=2. Without FWD_EX_TO_ID_EN and Branch_id=1 -> ForwardC=1 and stall=1.
- Whether_jump=1 with no hazard -> flush=1 and stall=0.
